// File: rtl/operand_pair_skid_buffer_pkg.sv
// rtl/operand_pair_skid_buffer_pkg.sv - state encodings and helpers for the operand pair skid buffer
package operand_pair_skid_buffer_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Encoding 2'd3 is unreachable; it reports zero occupancy while it recovers.
  function automatic logic [1:0] occupancy_of(input logic [1:0] state);
    case (state)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/operand_pair_skid_buffer_reg.sv
// rtl/operand_pair_skid_buffer_reg.sv - generic register with synchronous reset, clear and load enable
module operand_pair_skid_buffer_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/operand_pair_skid_buffer.sv
// rtl/operand_pair_skid_buffer.sv - two-entry elastic stage for an (A, B) operand pair
module operand_pair_skid_buffer
  import operand_pair_skid_buffer_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_a,
  input  logic [BUS_WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_a,
  output logic [BUS_WIDTH-1:0] out_b,
  output logic [1:0]           occupancy
);

  localparam int PW = 2 * BUS_WIDTH;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          in_fire;
  logic          out_fire;
  logic          main_en;
  logic          main_from_skid;
  logic          skid_en;
  logic          clr_data;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  // Ready depends only on state and reset, so it never combinationally follows out_ready.
  assign in_ready  = !rst && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = occupancy_of(state_q);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    clr_data       = flush;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      default: begin
        state_d  = ST_EMPTY;
        clr_data = 1'b1;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : {in_a, in_b};

  operand_pair_skid_buffer_reg #(.WIDTH(PW)) u_main_reg (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr_data),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  operand_pair_skid_buffer_reg #(.WIDTH(PW)) u_skid_reg (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr_data),
    .en_i  (skid_en),
    .d_i   ({in_a, in_b}),
    .q_o   (skid_q)
  );

  assign out_a = main_q[PW-1:BUS_WIDTH];
  assign out_b = main_q[BUS_WIDTH-1:0];

endmodule

// File: tb/tb_operand_pair_skid_buffer.sv
// tb/tb_operand_pair_skid_buffer.sv - self-checking bench for operand_pair_skid_buffer
module tb_operand_pair_skid_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_a, out_b;
  logic [1:0]  occupancy;

  logic        w_in_valid, w_out_ready;
  logic        rdy8, vld8, rdy64, vld64;
  logic [7:0]  a8, b8, oa8, ob8;
  logic [63:0] a64, b64, oa64, ob64;
  logic [1:0]  occ8, occ64;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  operand_pair_skid_buffer #(.BUS_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .occupancy(occupancy)
  );

  operand_pair_skid_buffer #(.BUS_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(w_in_valid), .in_ready(rdy8),
    .in_a(a8), .in_b(b8), .out_valid(vld8), .out_ready(w_out_ready),
    .out_a(oa8), .out_b(ob8), .occupancy(occ8)
  );

  operand_pair_skid_buffer #(.BUS_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(w_in_valid), .in_ready(rdy64),
    .in_a(a64), .in_b(b64), .out_valid(vld64), .out_ready(w_out_ready),
    .out_a(oa64), .out_b(ob64), .occupancy(occ64)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; a8 = '0; b8 = '0; a64 = '0; b64 = '0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_a !== 32'd0 || out_b !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%0b occ=%0d a=%h b=%h rdy=%0b want v=0 occ=0 a=0 b=0 rdy=1",
               out_valid, occupancy, out_a, out_b, in_ready);
    end
  endtask

  task automatic test_pass_through();
    logic [31:0] ea, eb;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        ea = 32'h11 + 32'(i - 1) * 32'h22;
        eb = ea + 32'h11;
        checks++;
        if (out_valid !== 1'b1 || out_a !== ea || out_b !== eb || occupancy !== 2'd1 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL pass_through[%0d] got v=%0b a=%h b=%h occ=%0d rdy=%0b want v=1 a=%h b=%h occ=1 rdy=1",
                   i, out_valid, out_a, out_b, occupancy, in_ready, ea, eb);
        end
      end
      out_ready = 1'b1;
      in_valid  = (i < 4);
      in_a      = 32'h11 + 32'(i) * 32'h22;
      in_b      = in_a + 32'h11;
    end
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL pass_drain got occ=%0d v=%0b want occ=0 v=0", occupancy, out_valid);
    end
  endtask

  task automatic test_stall_fill();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2;
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_a !== 32'h1 || out_b !== 32'h2) begin
      errors++; $display("FAIL stall_one got occ=%0d rdy=%0b a=%h b=%h want occ=1 rdy=1 a=1 b=2", occupancy, in_ready, out_a, out_b);
    end
    in_a = 32'h3; in_b = 32'h4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_a = 32'h5; in_b = 32'h6;
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 32'h1 || out_b !== 32'h2) begin
        errors++;
        $display("FAIL stall_full[%0d] got occ=%0d rdy=%0b v=%0b a=%h b=%h want occ=2 rdy=0 v=1 a=1 b=2",
                 k, occupancy, in_ready, out_valid, out_a, out_b);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_a !== 32'h3 || out_b !== 32'h4) begin
      errors++; $display("FAIL stall_release got occ=%0d v=%0b a=%h b=%h want occ=1 v=1 a=3 b=4", occupancy, out_valid, out_a, out_b);
    end
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain got occ=%0d v=%0b want occ=0 v=0 (ignored 5/6 must not appear)", occupancy, out_valid);
    end
  endtask

  task automatic test_stream(input int n, input bit random_ready, input string name);
    int          sent = 0, recv = 0, cycles = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] pa = '0, pb = '0;
    logic [63:0] exp;
    sb.delete();
    while (recv < n && cycles < 2000) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_a !== pa || out_b !== pb) begin
          errors++; $display("FAIL %s_stall_stable got v=%0b a=%h b=%h want v=1 a=%h b=%h", name, out_valid, out_a, out_b, pa, pb);
        end
      end
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < n);
      in_a      = 32'(sent);
      in_b      = ~32'(sent);
      #1;
      if (!random_ready && sent < n) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %0b want 1", name, in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL %s_unexpected got a=%h b=%h want no output", name, out_a, out_b);
        end else begin
          exp = sb.pop_front();
          if ({out_a, out_b} !== exp) begin
            errors++; $display("FAIL %s_data[%0d] got %h want %h", name, recv, {out_a, out_b}, exp);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_a, in_b});
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      pa = out_a; pb = out_b;
      cycles++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (recv != n || sb.size() != 0) begin
      errors++; $display("FAIL %s_count got recv=%0d left=%0d want recv=%0d left=0", name, recv, sb.size(), n);
    end
    if (!random_ready) begin
      checks++;
      if (cycles != n + 1) begin errors++; $display("FAIL %s_rate got %0d cycles want %0d", name, cycles, n + 1); end
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL %s_dup got v=%0b occ=%0d want v=0 occ=0", name, out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h51; in_b = 32'h52;
    @(negedge clk);
    in_a = 32'h53; in_b = 32'h54;
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill got occ=%0d want 2", occupancy); end
    flush = 1'b1; out_ready = 1'b1; in_a = 32'h55; in_b = 32'h56;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0) begin
      errors++; $display("FAIL flush_clear got occ=%0d v=%0b a=%h b=%h want occ=0 v=0 a=0 b=0", occupancy, out_valid, out_a, out_b);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d] got v=%0b a=%h want v=0", k, out_valid, out_a); end
    end
    in_valid = 1'b1; in_a = 32'h61; in_b = 32'h62;
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL flush_input_drop got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h71; in_b = 32'h72;
    @(negedge clk);
    in_a = 32'h73; in_b = 32'h74;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      errors++; $display("FAIL rst_mid_ready got rdy=%0b occ=%0d want rdy=0 occ=2", in_ready, occupancy);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; in_a = 32'hAA; in_b = 32'hBB;
    #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_clear got occ=%0d v=%0b a=%h b=%h rdy=%0b want occ=0 v=0 a=0 b=0 rdy=1",
               occupancy, out_valid, out_a, out_b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'hAA || out_b !== 32'hBB) begin
      errors++; $display("FAIL rst_mid_first got v=%0b a=%h b=%h want v=1 a=aa b=bb", out_valid, out_a, out_b);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_drain got v=%0b want 0", out_valid); end
  endtask

  task automatic test_illegal_state();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    force dut.state_q = 2'd3;
    #2;
    release dut.state_q;
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_recover got occ=%0d v=%0b rdy=%0b want occ=0 v=0 rdy=1", occupancy, out_valid, in_ready);
    end
  endtask

  task automatic test_width();
    @(negedge clk);
    w_out_ready = 1'b1; w_in_valid = 1'b1;
    a8 = '1; b8 = '0; a64 = '1; b64 = '0;
    @(negedge clk);
    w_in_valid = 1'b0;
    checks++;
    if (vld8 !== 1'b1 || oa8 !== 8'hFF || ob8 !== 8'h00) begin
      errors++; $display("FAIL width8 got v=%0b a=%h b=%h want v=1 a=ff b=00", vld8, oa8, ob8);
    end
    checks++;
    if (vld64 !== 1'b1 || oa64 !== 64'hFFFF_FFFF_FFFF_FFFF || ob64 !== 64'd0) begin
      errors++; $display("FAIL width64 got v=%0b a=%h b=%h want v=1 a=all-ones b=0", vld64, oa64, ob64);
    end
    @(negedge clk);
    checks++;
    if (occ8 !== 2'd0 || occ64 !== 2'd0) begin
      errors++; $display("FAIL width_drain got occ8=%0d occ64=%0d want 0 0", occ8, occ64);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall_fill();
    test_stream(100, 1'b1, "stream");
    test_stream(20, 1'b0, "full_rate");
    test_flush();
    test_reset_mid();
    test_illegal_state();
    test_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_pair_skid_buffer.md
Name: operand_pair_skid_buffer

Overview:
- Elastic pipeline stage carrying an operand pair (A, B) between register-read and execute.
- Valid/ready handshake on both sides replaces a bare enable, so downstream stalls never drop or duplicate a beat.
- A two-entry skid structure (main and skid) lets in_ready be a function of state only, cutting the combinational ready path. Full throughput is one pair per cycle.
- A flush input discards all buffered pairs on branch redirect.

Parameters:
- BUS_WIDTH, 32, width of each operand.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered pairs.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  buffer can accept a pair this cycle.
- in_a  input  BUS_WIDTH  operand A in.
- in_b  input  BUS_WIDTH  operand B in.
- out_valid  output  1  out_a/out_b hold a valid pair.
- out_ready  input  1  downstream accepts a pair this cycle.
- out_a  output  BUS_WIDTH  operand A out, driven directly from the main register.
- out_b  output  BUS_WIDTH  operand B out, driven directly from the main register.
- occupancy  output  2  number of buffered pairs (0, 1 or 2).

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !rst & (state != FULL). It depends only on state and rst, never on out_ready.
- out_valid = (state != EMPTY).
- occupancy is 0 in EMPTY, 1 in BUSY, 2 in FULL.
- States are EMPTY, BUSY (main register valid) and FULL (main and skid both valid).
- EMPTY:
  - in_fire -> main <= in; go to BUSY.
  - otherwise hold.
- BUSY:
  - in_fire & out_fire -> main <= in; stay BUSY.
  - in_fire only -> skid <= in; go to FULL.
  - out_fire only -> go to EMPTY.
  - neither -> hold.
- FULL:
  - in_ready = 0, so in_valid is ignored.
  - out_fire -> main <= skid; go to BUSY.
  - otherwise hold.
- Timing:
  - Latency is 1 cycle: a pair accepted at edge N appears on out_a/out_b with out_valid=1 after edge N.
  - The skid path adds 1 cycle per stalled beat.
- Ordering: strict FIFO. A pair in skid is never overtaken, and in_a is never bypassed to the output combinationally.
- Reset:
  - rst=1 at an edge -> state EMPTY; main and skid data cleared to 0.
  - After reset: out_a = out_b = 0, out_valid = 0, occupancy = 0.
  - in_ready = 0 while rst is high, and 1 from the first cycle after reset.
- Flush:
  - flush=1 at an edge has the same effect as reset, but in_ready is not forced low.
  - Any in_fire or out_fire in the flush cycle is discarded: state is EMPTY next cycle and data is cleared to 0.
  - rst has priority over flush.
- Stall stability: while out_valid=1 and out_ready=0, out_a/out_b/out_valid must remain stable. The bench checks this every stalled cycle.
- Data registers load only on the transitions above; there is no other write enable.

Decomposition:
- Shared header pipeline_defs.vh holds the state encodings as localparams: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
- Encoding 2'd3 is illegal. It recovers to EMPTY, and the bench covers this with a forced-state check.
- The main and skid data registers are instances of the team's generic enable-and-reset register (2*BUS_WIDTH wide, A and B concatenated). Their enables come from the FSM.
- The FSM stays inline; no further sub-module is needed.

Test Plan:
1. Reset then pass-through: rst for 2 cycles; then in_valid=1 with A=0x11, B=0x22 and out_ready=1.
   - Required: out_valid=1 with 0x11/0x22 one cycle later.
   - Required: in_ready=1 every cycle; occupancy stays 1.
2. Stall and fill: with out_ready=0, send (0x1,0x2) then (0x3,0x4).
   - Required: occupancy 1 then 2; in_ready=0 in FULL.
   - Required: outputs hold 0x1/0x2 while stalled.
   - Release out_ready -> (0x3,0x4) follows on the next cycle with no loss.
3. Streaming throughput: 100 back-to-back pairs, A=i and B=~i, with random out_ready at 50%.
   - Required: output sequence identical and in order; no duplicates.
   - Required: full-rate cycles achieve one pair per cycle.
4. Flush with both sides firing: occupancy 2, then assert flush together with out_ready=1 and in_valid=1.
   - Required: next cycle occupancy=0, out_valid=0, out_a=out_b=0.
   - Required: neither the flushed pairs nor the same-cycle input appear later.
5. Reset mid-stream: assert rst while in FULL with in_valid=1.
   - Required: in_ready=0 during rst.
   - Required: state EMPTY and outputs 0 after the edge; the first post-reset pair (0xAA,0xBB) emerges normally.
6. Width: BUS_WIDTH=8 and BUS_WIDTH=64 builds with A=all-ones, B=0.
   - Required: values pass through bit-exact on both builds.
